// File: rtl/bus_addr_reg_if.sv
// Command/status bundle for bus_addr_reg; bst_wrap exists only when BUS_ADDR_WRAP_EN is defined.
// master drives commands and observes status; slave is the register side.
interface bus_addr_reg_if #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
);
  logic [WIDTH-1:0] Din;
  logic             ld;
  logic             inc;
  logic             dec;
  logic             oe;
  logic             bst_start;
  logic [LEN_W-1:0] bst_len;
  logic             bst_adv;
  logic             clr_ovf;
`ifdef BUS_ADDR_WRAP_EN
  logic             bst_wrap;
`endif
  logic [WIDTH-1:0] Q;
  logic             bst_busy;
  logic             bst_done;
  logic             ovf;

  modport master (
    output Din, ld, inc, dec, oe, bst_start, bst_len, bst_adv, clr_ovf,
`ifdef BUS_ADDR_WRAP_EN
    output bst_wrap,
`endif
    input  Q, bst_busy, bst_done, ovf
  );

  modport slave (
    input  Din, ld, inc, dec, oe, bst_start, bst_len, bst_adv, clr_ovf,
`ifdef BUS_ADDR_WRAP_EN
    input  bst_wrap,
`endif
    output Q, bst_busy, bst_done, ovf
  );
endinterface

// File: rtl/bus_addr_reg.sv
// Bus address register: load, inc/dec by STEP, counted bursts with a registered done pulse; updates one cycle after the command.
// No backpressure: commands are accepted every cycle; BUS_ADDR_WRAP_EN adds aligned wrapping bursts.
module bus_addr_reg #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(1),
  parameter int               LEN_W = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  bus_addr_reg_if.slave   bus,
  output wire [WIDTH-1:0] Dout
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data, data_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic             done_q, done_nxt;
  logic             ovf_q, ovf_nxt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             wrap_act;
  logic [WIDTH-1:0] adv_addr;

  // Extra MSB carries the carry-out of the add and the borrow of the subtract.
  assign add_full = {1'b0, data} + {1'b0, STEP};
  assign sub_full = {1'b0, data} - {1'b0, STEP};

`ifdef BUS_ADDR_WRAP_EN
  logic                   wrap_q;
  logic [WIDTH-1:0]       wrap_mask_q;
  logic [WIDTH+LEN_W-1:0] blk_size;
  logic                   len_pow2;

  assign blk_size = (WIDTH+LEN_W)'(bus.bst_len) * (WIDTH+LEN_W)'(STEP);
  assign len_pow2 = (bus.bst_len != '0) && ((bus.bst_len & (bus.bst_len - LEN_W'(1))) == '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wrap_q      <= 1'b0;
      wrap_mask_q <= '0;
    end else if (state == IDLE && !bus.ld && bus.bst_start) begin
      wrap_q      <= bus.bst_wrap && len_pow2;
      wrap_mask_q <= WIDTH'(blk_size - (WIDTH+LEN_W)'(1));
    end
  end

  // Upper bits stay on the block base; only the in-block offset advances.
  assign wrap_act = wrap_q;
  assign adv_addr = wrap_q ? ((data & ~wrap_mask_q) | (add_full[WIDTH-1:0] & wrap_mask_q))
                           : add_full[WIDTH-1:0];
`else
  assign wrap_act = 1'b0;
  assign adv_addr = add_full[WIDTH-1:0];
`endif

  always_comb begin
    state_nxt     = state;
    data_nxt      = data;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
    ovf_nxt       = ovf_q & ~bus.clr_ovf;
    case (state)
      IDLE: begin
        if (bus.ld) begin
          data_nxt = bus.Din;
          ovf_nxt  = 1'b0;
        end else if (bus.bst_start) begin
          if (bus.bst_len != '0) begin
            remaining_nxt = bus.bst_len;
            state_nxt     = BURST;
          end else begin
            done_nxt = 1'b1;
          end
        end else if (bus.inc && !bus.dec) begin
          data_nxt = add_full[WIDTH-1:0];
          if (add_full[WIDTH]) ovf_nxt = 1'b1;
        end else if (bus.dec && !bus.inc) begin
          data_nxt = sub_full[WIDTH-1:0];
          if (sub_full[WIDTH]) ovf_nxt = 1'b1;
        end
      end
      BURST: begin
        if (bus.ld) begin
          data_nxt      = bus.Din;
          ovf_nxt       = 1'b0;
          remaining_nxt = '0;
          state_nxt     = IDLE;
        end else if (bus.bst_adv) begin
          data_nxt      = adv_addr;
          remaining_nxt = remaining - LEN_W'(1);
          if (!wrap_act && add_full[WIDTH]) ovf_nxt = 1'b1;
          if (remaining == LEN_W'(1)) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      data      <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      data      <= data_nxt;
      remaining <= remaining_nxt;
      done_q    <= done_nxt;
      ovf_q     <= ovf_nxt;
    end
  end

  assign bus.Q        = data;
  assign bus.bst_busy = (state == BURST);
  assign bus.bst_done = done_q;
  assign bus.ovf      = ovf_q;
  assign Dout         = bus.oe ? data : {WIDTH{1'bz}};

endmodule
